// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: operand buffer and skew generator in front of an N x N systolic array.
//
// Loads one N x N matrix A row by row (beats 0..N-1), then one N x N matrix B column by
// column (beats N..2N-1), over a valid/ready stream. It then drives the array's west
// (A rows) and north (B columns) edges for 2N-1 cycles with the diagonal skew the array
// needs, zero-filling lanes outside the active row/column range. A one-cycle done pulse
// follows the final feed word.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        load handshake
//   in_data                  one row of A or one column of B, element k at [k*WDATA +: WDATA]
//   row_cfg_in/col_cfg_in    active rows R / columns C, sampled on the last load beat
//   west_out/north_out       skewed lanes to the array, lane i at [i*WDATA +: WDATA]
//   row_cfg_out/col_cfg_out  latched (clamped) R / C forwarded to the array
//   feed_valid               high on each feed cycle
//   busy                     high in FEED and DONE
//   done                     one-cycle pulse after the final feed cycle
module sa_skew_feeder #(
   parameter int unsigned N         = 4,
   parameter int unsigned WDATA     = 4,
   parameter int unsigned CFG_WIDTH = $clog2(N) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N*WDATA-1:0]     in_data,
   input  logic [CFG_WIDTH-1:0]   row_cfg_in,
   input  logic [CFG_WIDTH-1:0]   col_cfg_in,
   output logic [N*WDATA-1:0]     west_out,
   output logic [N*WDATA-1:0]     north_out,
   output logic [CFG_WIDTH-1:0]   row_cfg_out,
   output logic [CFG_WIDTH-1:0]   col_cfg_out,
   output logic                   feed_valid,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned BW = $clog2(2 * N);  // beat counter and feed step counter
   localparam int unsigned IW = $clog2(N);      // row / column index

   typedef enum logic [1:0] {StIdle, StLoad, StFeed, StDone} state_e;

   state_e                 state_q, state_d;
   logic [BW-1:0]          beat_q, beat_d;
   logic [BW-1:0]          t_q, t_d;
   logic                   in_ready_q, in_ready_d;
   logic [N*WDATA-1:0]     west_q, west_d;
   logic [N*WDATA-1:0]     north_q, north_d;
   logic [CFG_WIDTH-1:0]   row_cfg_q, row_cfg_d;
   logic [CFG_WIDTH-1:0]   col_cfg_q, col_cfg_d;
   logic                   feed_valid_q, feed_valid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   // a_q[i][k] = A[i][k]; b_q[k][j] = B[k][j]
   logic [WDATA-1:0]       a_q [N][N];
   logic [WDATA-1:0]       b_q [N][N];

   logic                   loading;
   logic                   accept;
   logic                   last_beat;
   logic [BW-1:0]          feed_t;
   logic [CFG_WIDTH-1:0]   rows_eff;
   logic [CFG_WIDTH-1:0]   cols_eff;
   logic [N*WDATA-1:0]     west_word;
   logic [N*WDATA-1:0]     north_word;

   function automatic logic [CFG_WIDTH-1:0] clamp_cfg(input logic [CFG_WIDTH-1:0] v);
      if (v == '0 || v > CFG_WIDTH'(N)) begin
         return CFG_WIDTH'(N);
      end
      return v;
   endfunction

   assign loading   = (state_q == StIdle) || (state_q == StLoad);
   assign accept    = loading && in_valid && in_ready_q;
   assign last_beat = accept && (beat_q == BW'(2 * N - 1));

   // The word registered at the last-beat edge is t=0; it only reads A[0][0] and B[0][0],
   // both already stored, so no write bypass is needed.
   assign feed_t   = last_beat ? '0 : t_q + 1'b1;
   assign rows_eff = last_beat ? clamp_cfg(row_cfg_in) : row_cfg_q;
   assign cols_eff = last_beat ? clamp_cfg(col_cfg_in) : col_cfg_q;

   // Lane i carries A[i][k] when k = t - i; lane j carries B[k][j] when k = t - j.
   always_comb begin
      west_word  = '0;
      north_word = '0;
      for (int i = 0; i < int'(N); i++) begin
         for (int k = 0; k < int'(N); k++) begin
            if ((i + k) == int'(feed_t) && i < int'(rows_eff)) begin
               west_word[i*WDATA +: WDATA] = a_q[i][k];
            end
            if ((i + k) == int'(feed_t) && i < int'(cols_eff)) begin
               north_word[i*WDATA +: WDATA] = b_q[k][i];
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      t_d          = t_q;
      row_cfg_d    = row_cfg_q;
      col_cfg_d    = col_cfg_q;
      west_d       = '0;
      north_d      = '0;
      feed_valid_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;

      unique case (state_q)
         StIdle, StLoad: begin
            if (accept) begin
               beat_d  = beat_q + 1'b1;
               state_d = StLoad;
               if (last_beat) begin
                  state_d      = StFeed;
                  t_d          = '0;
                  row_cfg_d    = rows_eff;
                  col_cfg_d    = cols_eff;
                  west_d       = west_word;
                  north_d      = north_word;
                  feed_valid_d = 1'b1;
                  busy_d       = 1'b1;
               end
            end
         end
         StFeed: begin
            busy_d = 1'b1;
            if (t_q == BW'(2 * N - 2)) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else begin
               t_d          = feed_t;
               west_d       = west_word;
               north_d      = north_word;
               feed_valid_d = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            beat_d  = '0;
         end
         default: begin
            state_d = StIdle;
            beat_d  = '0;
         end
      endcase

      in_ready_d = (state_d == StIdle) || (state_d == StLoad);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         beat_q       <= '0;
         t_q          <= '0;
         in_ready_q   <= 1'b0;
         west_q       <= '0;
         north_q      <= '0;
         row_cfg_q    <= CFG_WIDTH'(N);
         col_cfg_q    <= CFG_WIDTH'(N);
         feed_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         t_q          <= t_d;
         in_ready_q   <= in_ready_d;
         west_q       <= west_d;
         north_q      <= north_d;
         row_cfg_q    <= row_cfg_d;
         col_cfg_q    <= col_cfg_d;
         feed_valid_q <= feed_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Operand storage needs no reset; every entry is rewritten before it is fed.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < int'(N); k++) begin
            if (beat_q < BW'(N)) begin
               a_q[IW'(beat_q)][k] <= in_data[k*WDATA +: WDATA];
            end else begin
               b_q[k][IW'(beat_q - BW'(N))] <= in_data[k*WDATA +: WDATA];
            end
         end
      end
   end

   assign in_ready    = in_ready_q;
   assign west_out    = west_q;
   assign north_out   = north_q;
   assign row_cfg_out = row_cfg_q;
   assign col_cfg_out = col_cfg_q;
   assign feed_valid  = feed_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Randomized self-checking bench for sa_skew_feeder (N=4, WDATA=4). Expected edge
// sequences are built by placing each matrix element at its diagonal time slot.
module tb_sa_skew_feeder;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int CW = $clog2(N) + 1;
   localparam int NW = N * W;
   localparam int T  = 2 * N - 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [NW-1:0]  in_data = '0;
   logic [CW-1:0]  row_cfg_in = '0;
   logic [CW-1:0]  col_cfg_in = '0;
   logic [NW-1:0]  west_out;
   logic [NW-1:0]  north_out;
   logic [CW-1:0]  row_cfg_out;
   logic [CW-1:0]  col_cfg_out;
   logic           feed_valid;
   logic           busy;
   logic           done;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] ma [N][N];  // ma[i][k] = A[i][k]
   logic [W-1:0] mb [N][N];  // mb[k][j] = B[k][j]

   sa_skew_feeder #(.N(N), .WDATA(W), .CFG_WIDTH(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .row_cfg_in  (row_cfg_in),
      .col_cfg_in  (col_cfg_in),
      .west_out    (west_out),
      .north_out   (north_out),
      .row_cfg_out (row_cfg_out),
      .col_cfg_out (col_cfg_out),
      .feed_valid  (feed_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int clampc(input int v);
      return (v == 0 || v > N) ? N : v;
   endfunction

   task automatic fill_plan();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[i][k] = W'(i + k);
            mb[k][i] = W'(k + 1);
         end
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[i][k] = W'($urandom);
            mb[i][k] = W'($urandom);
         end
   endtask

   // Sends nbeats load beats; cfg is only meaningful on beat 2N-1, earlier beats carry junk.
   task automatic load(input int nbeats, input int rcfg, input int ccfg, input int maxgap);
      int to;
      @(posedge clk); #1;
      for (int b = 0; b < nbeats; b++) begin
         if (maxgap > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, maxgap)) begin @(posedge clk); #1; end
         end
         for (int k = 0; k < N; k++)
            in_data[k*W +: W] = (b < N) ? ma[b][k] : mb[k][b-N];
         row_cfg_in = (b == 2*N-1) ? CW'(rcfg) : CW'($urandom);
         col_cfg_in = (b == 2*N-1) ? CW'(ccfg) : CW'($urandom);
         in_valid = 1'b1;
         to = 0;
         @(negedge clk);
         while (!in_ready && to < 20) begin @(negedge clk); to++; end
         check($sformatf("load_ready_b%0d", b), 64'(in_ready), 64'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_feed(input int rcfg, input int ccfg, input bit hold_valid,
                           input int rst_at);
      logic [NW-1:0] ew [T];
      logic [NW-1:0] en [T];
      int r, c;
      r = clampc(rcfg);
      c = clampc(ccfg);
      for (int t = 0; t < T; t++) begin ew[t] = '0; en[t] = '0; end
      for (int i = 0; i < r; i++)
         for (int k = 0; k < N; k++) ew[i+k][i*W +: W] = ma[i][k];
      for (int j = 0; j < c; j++)
         for (int k = 0; k < N; k++) en[k+j][j*W +: W] = mb[k][j];
      if (hold_valid) begin
         in_valid = 1'b1;
         in_data  = NW'($urandom);
      end
      for (int t = 0; t < T; t++) begin
         @(negedge clk);
         check($sformatf("west_t%0d", t), 64'(west_out), 64'(ew[t]));
         check($sformatf("north_t%0d", t), 64'(north_out), 64'(en[t]));
         check($sformatf("fv_t%0d", t), 64'(feed_valid), 64'd1);
         check($sformatf("busy_t%0d", t), 64'(busy), 64'd1);
         check($sformatf("ready_t%0d", t), 64'(in_ready), 64'd0);
         check($sformatf("done_t%0d", t), 64'(done), 64'd0);
         if (t == 0) begin
            check("row_cfg_out", 64'(row_cfg_out), 64'(r));
            check("col_cfg_out", 64'(col_cfg_out), 64'(c));
         end
         if (t == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            in_valid = 1'b0;
            check("rst_west", 64'(west_out), 64'd0);
            check("rst_north", 64'(north_out), 64'd0);
            check("rst_fv", 64'(feed_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_ready", 64'(in_ready), 64'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int n = 0; n < 10; n++) begin
               @(negedge clk);
               check("rst_no_done", 64'(done), 64'd0);
            end
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd1);
      check("done_busy", 64'(busy), 64'd1);
      check("done_fv", 64'(feed_valid), 64'd0);
      check("done_west", 64'(west_out), 64'd0);
      check("done_north", 64'(north_out), 64'd0);
      check("done_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_done", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      // Reset state
      #12;
      check("reset_ready", 64'(in_ready), 64'd0);
      check("reset_west", 64'(west_out), 64'd0);
      check("reset_north", 64'(north_out), 64'd0);
      check("reset_fv", 64'(feed_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_rcfg", 64'(row_cfg_out), 64'd4);
      check("reset_ccfg", 64'(col_cfg_out), 64'd4);
      @(negedge clk);
      rst_n = 1'b1;
      check("release_ready0", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check("release_ready1", 64'(in_ready), 64'd1);

      // Full feed and partial config on the plan data
      fill_plan();
      load(2*N, 4, 4, 0);
      run_feed(4, 4, 1'b0, -1);
      load(2*N, 2, 3, 0);
      run_feed(2, 3, 1'b0, -1);

      // Reset mid-LOAD discards the partial load and restores cfg defaults
      fill_random();
      load(3, 4, 4, 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_load_ready", 64'(in_ready), 64'd0);
      check("mid_load_west", 64'(west_out), 64'd0);
      check("mid_load_north", 64'(north_out), 64'd0);
      check("mid_load_fv", 64'(feed_valid), 64'd0);
      check("mid_load_rcfg", 64'(row_cfg_out), 64'd4);
      check("mid_load_ccfg", 64'(col_cfg_out), 64'd4);
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_load_rel0", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check("mid_load_rel1", 64'(in_ready), 64'd1);

      // Clamp
      fill_plan();
      load(2*N, 0, 7, 0);
      run_feed(0, 7, 1'b0, -1);

      // Stalled load gives the same sequence as the gap-free one
      load(2*N, 4, 4, 3);
      run_feed(4, 4, 1'b0, -1);

      // in_valid held through FEED is ignored
      fill_random();
      load(2*N, 4, 4, 0);
      run_feed(4, 4, 1'b1, -1);

      // Random configs
      for (int n = 0; n < 4; n++) begin
         int rc, cc;
         rc = $urandom_range(0, 7);
         cc = $urandom_range(0, 7);
         fill_random();
         load(2*N, rc, cc, n % 2 == 1 ? 2 : 0);
         run_feed(rc, cc, 1'b0, -1);
      end

      // Reset mid-FEED, then a fresh load
      fill_random();
      load(2*N, 4, 4, 0);
      run_feed(4, 4, 1'b0, 3);
      fill_random();
      load(2*N, 3, 2, 0);
      run_feed(3, 2, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
